// File: rtl/lcd_timed_ctrl_if.sv
// Avalon-MM slave port of the timed character-LCD controller.
// Handshake: a transfer is requested while read or write is high and completes in
// the cycle waitrequest is low; the master holds address, writedata and both
// strobes stable until that cycle.
interface lcd_timed_ctrl_if;
    logic [1:0] address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/lcd_timed_ctrl.sv
// HD44780-style LCD controller: stretches each Avalon access into a timed
// setup / E-pulse / hold sequence, in one 8-bit pass or two 4-bit nibble passes.
module lcd_timed_ctrl #(
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    lcd_timed_ctrl_if.slave   avs,
    output logic              LCD_E,
    output logic              LCD_RS,
    output logic              LCD_RW,
    inout  wire  [DATA_W-1:0] LCD_data,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               nib_q, nib_d;
    logic               rs_q, rs_d;
    logic               rw_q, rw_d;
    logic               e_q, e_d;
    logic               oe_q, oe_d;
    logic [7:0]         byte_q, byte_d;
    logic [7:0]         rx_q, rx_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               phase_last;
    logic [DATA_W-1:0]  bus_out;
    logic [7:0]         rx_sample;

    // In nibble mode the first pass (nib_q=0) carries the high nibble.
    generate
        if (DATA_W == 4) begin : g_nibble
            assign bus_out   = nib_q ? byte_q[3:0] : byte_q[7:4];
            assign rx_sample = nib_q ? {rx_q[7:4], LCD_data} : {LCD_data, rx_q[3:0]};
        end else begin : g_byte
            assign bus_out   = byte_q;
            assign rx_sample = LCD_data;
        end
    endgenerate

    assign LCD_data        = oe_q ? bus_out : {DATA_W{1'bz}};
    assign LCD_E           = e_q;
    assign LCD_RS          = rs_q;
    assign LCD_RW          = rw_q;
    assign dbg_state       = state_q;
    assign avs.readdata    = rdata_q;
    assign avs.waitrequest = (avs.read | avs.write) & (state_q != DONE);

    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            SETUP:   phase_last = (cnt_q == SETUP_LAST);
            PULSE:   phase_last = (cnt_q == PULSE_LAST);
            HOLD:    phase_last = (cnt_q == HOLD_LAST);
            default: phase_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        nib_d   = nib_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        byte_d  = byte_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (avs.read | avs.write) begin
                    // A simultaneous read+write is performed as a write.
                    rs_d    = avs.address[1];
                    rw_d    = avs.address[0] & ~avs.write;
                    byte_d  = avs.write ? avs.writedata : 8'h00;
                    state_d = SETUP;
                end
            end
            SETUP: if (phase_last) state_d = PULSE;
            PULSE: begin
                if (phase_last) begin
                    state_d = HOLD;
                    if (rw_q) rx_d = rx_sample;
                end
            end
            HOLD: begin
                if (phase_last) begin
                    if ((DATA_W == 4) && !nib_q) begin
                        nib_d   = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                        if (rw_q) rdata_d = rx_q;
                    end
                end
            end
            DONE: begin
                nib_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q || state_q == IDLE) cnt_d = '0;
        e_d  = (state_d == PULSE);
        oe_d = ~rw_d & ((state_d == SETUP) | (state_d == PULSE) | (state_d == HOLD));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nib_q   <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b1;
            e_q     <= 1'b0;
            oe_q    <= 1'b0;
            byte_q  <= 8'h00;
            rx_q    <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            e_q     <= e_d;
            oe_q    <= oe_d;
            byte_q  <= byte_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
